// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared encodings for the memory controller: access sizes,
//               direction, requester source, FSM states and IO window default.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam logic [1:0]  SZ_BYTE  = 2'd0;
    localparam logic [1:0]  SZ_HALF  = 2'd1;
    localparam logic [1:0]  SZ_WORD  = 2'd2;

    localparam logic        WAY_LOAD  = 1'b0;
    localparam logic        WAY_STORE = 1'b1;

    localparam logic        SRC_LSB = 1'b0;
    localparam logic        SRC_IF  = 1'b1;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;
    localparam int unsigned IO_SPAN_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Number of bus bytes for a size code; the unused code behaves as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_ext.sv
`default_nettype none
// ============================================================================
// Module      : mem_ext_unit
// Description : Combinational load extension of an assembled little-endian
//               value: sign or zero extension of byte and half loads.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ext_unit
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    output logic [31:0] ext_o
);

    // Replicate the top bit of the loaded field unless the load is unsigned.
    always_comb begin
        ext_o = raw_i;
        case (size_i)
            SZ_BYTE: ext_o = {{24{~uns_i & raw_i[7]}},  raw_i[7:0]};
            SZ_HALF: ext_o = {{16{~uns_i & raw_i[15]}}, raw_i[15:0]};
            default: ext_o = raw_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Arbitrates LSB and instruction-fetch requests and serialises
//               them into byte accesses on the 8-bit RAM/IO bus.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT,
    parameter int unsigned IO_SPAN = IO_SPAN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        need_cache,
    input  logic [2:0]  cache_size,
    input  logic [31:0] cache_addr,
    input  logic        cache_way,
    input  logic [31:0] cache_value,
    output logic        cache_ready,
    output logic [31:0] cache_result,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_inst,
    input  logic        flush,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    state_e      state_q, state_d;
    logic        src_q, src_d;
    logic        way_q, way_d;
    logic        uns_q, uns_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] value_q, value_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        wr_q, wr_d;

    logic [2:0]  w_nbytes;
    logic [2:0]  w_next;
    logic [1:0]  w_cap_idx;
    logic [31:0] w_io_off;
    logic        w_stall;
    logic        w_done;
    logic [31:0] w_ext;

    assign w_nbytes  = size_bytes(size_q);
    assign w_next    = cnt_q + 3'd1;
    // Read byte captured in counter step c belongs to lane c-2.
    assign w_cap_idx = cnt_q[1:0] - 2'd2;
    // Unsigned offset test also handles windows near the top of the space.
    assign w_io_off  = mem_a_q - IO_BASE;
    assign w_stall   = wr_q & (w_io_off < 32'(IO_SPAN)) & io_buffer_full;

    // Register the state machine and the byte-sequencer datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_LSB;
            way_q      <= WAY_LOAD;
            uns_q      <= 1'b0;
            size_q     <= SZ_BYTE;
            addr_q     <= 32'd0;
            value_q    <= 32'd0;
            cnt_q      <= 3'd0;
            data_q     <= 32'd0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            way_q      <= way_d;
            uns_q      <= uns_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            value_q    <= value_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            wr_q       <= wr_d;
        end
    end

    // Arbitration, next-state and bus sequencing; everything holds while rdy is low.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        way_d      = way_q;
        uns_d      = uns_q;
        size_d     = size_q;
        addr_d     = addr_q;
        value_d    = value_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        wr_d       = wr_q;
        if (rdy) begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d  = 3'd0;
                    data_d = 32'd0;
                    wr_d   = 1'b0;
                    if (need_cache) begin
                        src_d   = SRC_LSB;
                        way_d   = cache_way;
                        size_d  = cache_size[1:0];
                        uns_d   = cache_size[2];
                        addr_d  = cache_addr;
                        value_d = cache_value;
                        state_d = (cache_way == WAY_STORE) ? ST_WRITE : ST_READ;
                    end else if (if_valid && !flush) begin
                        src_d   = SRC_IF;
                        way_d   = WAY_LOAD;
                        size_d  = SZ_WORD;
                        uns_d   = 1'b1;
                        addr_d  = if_addr;
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    if (src_q == SRC_IF && flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Address issue runs two steps ahead of data capture.
                        if (cnt_q < w_nbytes) begin
                            mem_a_d = addr_q + 32'(cnt_q);
                        end
                        if (cnt_q >= 3'd2) begin
                            data_d[{w_cap_idx, 3'b000} +: 8] = mem_din;
                        end
                        if (cnt_q == w_nbytes + 3'd1) begin
                            state_d = ST_DONE;
                        end
                        cnt_d = w_next;
                    end
                end
                ST_WRITE: begin
                    if (!wr_q) begin
                        // Setup step: present the first byte.
                        mem_a_d    = addr_q + 32'(cnt_q);
                        mem_dout_d = value_q[{cnt_q[1:0], 3'b000} +: 8];
                        wr_d       = 1'b1;
                    end else if (!w_stall) begin
                        if (cnt_q == w_nbytes - 3'd1) begin
                            wr_d    = 1'b0;
                            state_d = ST_DONE;
                        end else begin
                            cnt_d      = w_next;
                            mem_a_d    = addr_q + 32'(w_next);
                            mem_dout_d = value_q[{w_next[1:0], 3'b000} +: 8];
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    mem_ext_unit u_ext (
        .raw_i  (data_q),
        .size_i (size_q),
        .uns_i  (uns_q),
        .ext_o  (w_ext)
    );

    assign w_done       = rdy & (state_q == ST_DONE);
    assign cache_ready  = w_done & (src_q == SRC_LSB);
    assign if_ready     = w_done & (src_q == SRC_IF) & ~flush;
    assign cache_result = (cache_ready && way_q == WAY_LOAD) ? w_ext : 32'd0;
    assign if_inst      = if_ready ? w_ext : 32'd0;
    assign mem_a        = mem_a_q;
    assign mem_dout     = mem_dout_q;
    assign mem_wr       = rdy & wr_q & ~w_stall;

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Responder for the load/store buffer's cache request interface, and the instruction-fetch server. Serialises each request into byte accesses on the 8-bit unified RAM/IO bus, assembles little-endian results and applies sign or zero extension. Returns a one-cycle ready pulse to the requester. Sits between the load/store buffer plus instruction fetch and the external memory bus.

Parameters:
IO_BASE, 32'h0003_0000, first byte address of the memory-mapped IO window.
IO_SPAN, 8, number of bytes in the IO window; stores there obey io_buffer_full.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
rdy  in  1  global enable; low freezes all state.
need_cache  in  1  LSB request, held high with stable fields until cache_ready.
cache_size  in  3  [1:0] 0=byte, 1=half, 2=word; [2]=1 zero-extend load.
cache_addr  in  32  byte address.
cache_way  in  1  1 store, 0 load.
cache_value  in  32  store data, low bytes used.
cache_ready  out  1  one-cycle completion pulse to LSB.
cache_result  out  32  extended load data, valid while cache_ready; 0 for stores.
if_valid  in  1  fetch request, held until if_ready or flush.
if_addr  in  32  fetch address.
if_ready  out  1  one-cycle fetch completion pulse.
if_inst  out  32  fetched word, valid while if_ready.
flush  in  1  mispredict clear; aborts fetch only.
mem_din  in  8  RAM read byte, one cycle after address.
mem_dout  out  8  write byte.
mem_a  out  32  byte address.
mem_wr  out  1  1 write, 0 read.
io_buffer_full  in  1  IO write back-pressure.

Behaviour:
- Reset (async, rst_n low, mid-transaction included): state IDLE; cache_ready, if_ready, mem_wr 0; mem_a, mem_dout, cache_result, if_inst, byte counter 0.
- rdy low: no state, counter or output-register change; mem_wr forced 0.
- States: IDLE, READ, WRITE, DONE.
- IDLE: need_cache has priority over if_valid. Accept at edge E0. Latch addr, size, way, value and source (LSB/IF). Go to READ for loads and fetches (fetch = word, unsigned), WRITE for stores. Counter = 0.
- Cycle k is the cycle after edge Ek. N = 1/2/4 bytes.
- READ: address addr+i on mem_a in cycle i+1, i = 0..N-1, with mem_wr 0. Byte i sampled from mem_din in cycle i+2 into bits [8i+7:8i]. After the last capture go to DONE; the ready pulse is high in cycle N+2.
- WRITE: byte i of value and addr+i driven with mem_wr 1 in cycle i+1. DONE follows, so cache_ready is high in cycle N+1.
- IO stall: if addr+i falls in [IO_BASE, IO_BASE+IO_SPAN) and io_buffer_full is high, drive mem_wr 0. Counter holds and the write retries each cycle until io_buffer_full is low.
- DONE: exactly one pulse, cache_ready for LSB or if_ready for IF. Next state is IDLE.
- No request is accepted in the DONE cycle, because the requester still shows the old request then. The minimum gap is one IDLE cycle.
- Extension: unsigned byte/half loads zero-extend; signed loads replicate bit 7 or bit 15.
- Address arithmetic is 32-bit and wraps modulo 2^32. No alignment requirement.
- flush high while serving IF (READ or DONE): go to IDLE next edge, suppress if_ready, and drop any pending if_valid that cycle.
- flush never affects an LSB transaction, including partially written stores.
- need_cache and if_valid in the same IDLE cycle: LSB is served first; fetch waits.
- mem_a holds its last value when idle; mem_wr is 0 outside WRITE.

Decomposition:
- Shared const.v: size encodings (byte/half/word, unsigned flag), way encoding, state encodings, IO_BASE default.
- One natural sub-module: mem_ext_unit. It is combinational load extension of the assembled 32-bit value by size and unsigned flag.
- Arbiter and byte sequencer stay in mem_ctrl.

Test Plan:
- Word load: RAM[0x100..0x103]=78 56 34 12, request size=2, way=0 at E0. Required: mem_a=0x100..0x103 in cycles 1-4; cache_ready in cycle 6 only; cache_result=0x12345678.
- Signed byte load of 0x80 returns 0xFFFFFF80. Same byte with size=3'b100 returns 0x00000080. Signed half 0x8001 returns 0xFFFF8001.
- Half store value=0xAABBCCDD to 0x200. Required: mem_wr=1 with 0x200/DD in cycle 1 and 0x201/CC in cycle 2; cache_ready in cycle 3; cache_result=0.
- Byte store to 0x30000 with io_buffer_full high for 3 cycles. Required: mem_wr held 0 for those cycles; write occurs in the first non-full cycle; cache_ready the cycle after.
- need_cache and if_valid asserted together. Required: LSB served first, then a one-cycle IDLE gap, then fetch. Flush in the fetch's cycle 3 gives no if_ready and IDLE next.
- rst_n pulsed low during the cycle-2 byte of a store. Required: outputs reset immediately and no further write; a new load after release completes normally.
